trap_sequencer: RTL and testbench

- Trap-entry controller for the SPARC datapath.
- Collects synchronous exception requests, Ticc software traps and external interrupt levels, then selects the highest-priority one and produces the 8-bit trap type (tt).
- Drives the datapath through the trap-entry sequence: PSR update, save PC/nPC into the new window's r17/r18, load tt into TBR, vector PC to TBR.
- Sits beside the PSR, TBR and register-file write port; holds the pipeline while sequencing.

---
 rtl/trap_pkg.sv | 56 +++++
 rtl/trap_prio_enc.sv | 44 ++++
 rtl/trap_sequencer.sv | 117 +++++++++++
 tb/tb_trap_sequencer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/trap_pkg.sv
// Shared trap-type codes, exception bit indices and sequencer state encodings
// for the SPARC trap-entry controller.
package trap_pkg;

  localparam int unsigned EXC_N = 9;

  localparam logic [7:0] TT_INSTR_ACCESS   = 8'h01;
  localparam logic [7:0] TT_PRIVILEGED     = 8'h03;
  localparam logic [7:0] TT_ILLEGAL        = 8'h02;
  localparam logic [7:0] TT_FP_DISABLED    = 8'h04;
  localparam logic [7:0] TT_WIN_OVERFLOW   = 8'h05;
  localparam logic [7:0] TT_WIN_UNDERFLOW  = 8'h06;
  localparam logic [7:0] TT_MEM_NOT_ALIGN  = 8'h07;
  localparam logic [7:0] TT_DATA_ACCESS    = 8'h09;
  localparam logic [7:0] TT_TAG_OVERFLOW   = 8'h0A;
  localparam logic [7:0] TT_TICC_BASE      = 8'h80;
  localparam logic [7:0] TT_IRQ_BASE       = 8'h10;

  localparam int unsigned EXC_INSTR_ACCESS  = 0;
  localparam int unsigned EXC_PRIVILEGED    = 1;
  localparam int unsigned EXC_ILLEGAL       = 2;
  localparam int unsigned EXC_FP_DISABLED   = 3;
  localparam int unsigned EXC_WIN_OVERFLOW  = 4;
  localparam int unsigned EXC_WIN_UNDERFLOW = 5;
  localparam int unsigned EXC_MEM_NOT_ALIGN = 6;
  localparam int unsigned EXC_DATA_ACCESS   = 7;
  localparam int unsigned EXC_TAG_OVERFLOW  = 8;

  localparam int unsigned ST_W = 3;
  localparam logic [ST_W-1:0] ST_IDLE     = 3'd0;
  localparam logic [ST_W-1:0] ST_ENTER    = 3'd1;
  localparam logic [ST_W-1:0] ST_SAVE_PC  = 3'd2;
  localparam logic [ST_W-1:0] ST_SAVE_NPC = 3'd3;
  localparam logic [ST_W-1:0] ST_VECTOR   = 3'd4;
  localparam logic [ST_W-1:0] ST_ERROR    = 3'd5;

  // Trap type for a given exc_req bit position.
  function automatic logic [7:0] exc_tt(input logic [3:0] idx);
    logic [7:0] code;
    code = 8'h00;
    case (32'(idx))
      EXC_INSTR_ACCESS:  code = TT_INSTR_ACCESS;
      EXC_PRIVILEGED:    code = TT_PRIVILEGED;
      EXC_ILLEGAL:       code = TT_ILLEGAL;
      EXC_FP_DISABLED:   code = TT_FP_DISABLED;
      EXC_WIN_OVERFLOW:  code = TT_WIN_OVERFLOW;
      EXC_WIN_UNDERFLOW: code = TT_WIN_UNDERFLOW;
      EXC_MEM_NOT_ALIGN: code = TT_MEM_NOT_ALIGN;
      EXC_DATA_ACCESS:   code = TT_DATA_ACCESS;
      EXC_TAG_OVERFLOW:  code = TT_TAG_OVERFLOW;
      default:           code = 8'h00;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/trap_prio_enc.sv
// Combinational trap-source arbiter: exceptions (bit0 first), then Ticc,
// then a maskable/NMI interrupt level.
module trap_prio_enc
  import trap_pkg::*;
#(
  parameter int unsigned TT_W = 8
) (
  input  logic [EXC_N-1:0] i_exc_req,
  input  logic             i_ticc_req,
  input  logic [6:0]       i_ticc_num,
  input  logic [3:0]       i_irl,
  input  logic [3:0]       i_psr_pil,
  input  logic             i_psr_et,
  output logic             o_valid,
  output logic             o_sync,
  output logic [TT_W-1:0]  o_tt
);

  logic       w_exc_any;
  logic       w_irq_ok;
  logic [7:0] w_exc_tt;

  always_comb begin
    w_exc_any = |i_exc_req;
    // Level 15 is non-maskable by PIL but still needs traps enabled.
    w_irq_ok  = i_psr_et && (i_irl != 4'd0) &&
                ((i_irl == 4'hF) || (i_irl > i_psr_pil));
    w_exc_tt  = 8'h00;
    for (int i = EXC_N - 1; i >= 0; i--) begin
      if (i_exc_req[i]) w_exc_tt = exc_tt(4'(i));
    end
    o_valid = w_exc_any | i_ticc_req | w_irq_ok;
    o_sync  = w_exc_any | i_ticc_req;
    if (w_exc_any)
      o_tt = TT_W'(w_exc_tt);
    else if (i_ticc_req)
      o_tt = TT_W'(TT_TICC_BASE | {1'b0, i_ticc_num});
    else if (w_irq_ok)
      o_tt = TT_W'(TT_IRQ_BASE | {4'b0000, i_irl});
    else
      o_tt = '0;
  end

endmodule

// File: rtl/trap_sequencer.sv
// SPARC trap-entry controller: arbitrates trap sources and steps the datapath
// through PSR update, r17/r18 save, TBR.tt load and vectoring.
module trap_sequencer
  import trap_pkg::*;
#(
  parameter int unsigned NWINDOWS = 8,
  parameter int unsigned TT_W     = 8,
  localparam int unsigned CWP_W   = $clog2(NWINDOWS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [EXC_N-1:0]  exc_req,
  input  logic              ticc_req,
  input  logic [6:0]        ticc_num,
  input  logic [3:0]        irl,
  input  logic              psr_et,
  input  logic [3:0]        psr_pil,
  input  logic [CWP_W-1:0]  psr_cwp,
  input  logic              dp_hold,
  output logic [TT_W-1:0]   tt,
  output logic              trap_busy,
  output logic              psr_trap_wr,
  output logic [CWP_W-1:0]  new_cwp,
  output logic              rf_we,
  output logic              rf_sel,
  output logic              tbr_tt_wr,
  output logic              pc_load_tbr,
  output logic              error_mode
);

  logic [ST_W-1:0]  r_state, w_state_nxt;
  logic [TT_W-1:0]  r_tt, w_tt_nxt;
  logic [CWP_W-1:0] r_new_cwp, w_cwp_nxt, w_cwp_dec;
  logic             w_valid, w_sync;
  logic [TT_W-1:0]  w_req_tt;

  trap_prio_enc #(.TT_W(TT_W)) u_prio (
    .i_exc_req  (exc_req),
    .i_ticc_req (ticc_req),
    .i_ticc_num (ticc_num),
    .i_irl      (irl),
    .i_psr_pil  (psr_pil),
    .i_psr_et   (psr_et),
    .o_valid    (w_valid),
    .o_sync     (w_sync),
    .o_tt       (w_req_tt)
  );

  // Entering a trap decrements CWP, wrapping from 0 to the top window.
  assign w_cwp_dec = (psr_cwp == '0) ? CWP_W'(NWINDOWS - 1) : psr_cwp - CWP_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_tt      <= '0;
      r_new_cwp <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_tt      <= w_tt_nxt;
      r_new_cwp <= w_cwp_nxt;
    end
  end

  // Next state and strobes; dp_hold freezes everything and masks strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_tt_nxt    = r_tt;
    w_cwp_nxt   = r_new_cwp;
    psr_trap_wr = 1'b0;
    tbr_tt_wr   = 1'b0;
    rf_we       = 1'b0;
    rf_sel      = 1'b0;
    pc_load_tbr = 1'b0;
    if (!dp_hold) begin
      case (r_state)
        ST_IDLE: begin
          if (w_valid) begin
            if (w_sync && !psr_et) begin
              w_state_nxt = ST_ERROR;
            end else begin
              w_state_nxt = ST_ENTER;
              w_tt_nxt    = w_req_tt;
              w_cwp_nxt   = w_cwp_dec;
            end
          end
        end
        ST_ENTER: begin
          psr_trap_wr = 1'b1;
          tbr_tt_wr   = 1'b1;
          w_state_nxt = ST_SAVE_PC;
        end
        ST_SAVE_PC: begin
          rf_we       = 1'b1;
          w_state_nxt = ST_SAVE_NPC;
        end
        ST_SAVE_NPC: begin
          rf_we       = 1'b1;
          rf_sel      = 1'b1;
          w_state_nxt = ST_VECTOR;
        end
        ST_VECTOR: begin
          pc_load_tbr = 1'b1;
          w_state_nxt = ST_IDLE;
        end
        ST_ERROR: w_state_nxt = ST_ERROR;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Busy rises in the accepting cycle so the pipeline stalls immediately.
  assign trap_busy  = ~reset & ((r_state != ST_IDLE) | (w_valid & ~dp_hold));
  assign error_mode = (r_state == ST_ERROR);
  assign tt         = r_tt;
  assign new_cwp    = r_new_cwp;

endmodule

// File: tb/tb_trap_sequencer.sv
// Self-checking bench for trap_sequencer: directed vector table, hand-built
// hold/reset sequences and randomized requests against a behavioural model.
module tb_trap_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [8:0] exc_req;
  logic       ticc_req;
  logic [6:0] ticc_num;
  logic [3:0] irl;
  logic       psr_et;
  logic [3:0] psr_pil;
  logic [2:0] psr_cwp;
  logic       dp_hold;
  logic [7:0] tt;
  logic       trap_busy, psr_trap_wr, rf_we, rf_sel, tbr_tt_wr, pc_load_tbr, error_mode;
  logic [2:0] new_cwp;

  int n_vec = 0;
  int n_err = 0;

  trap_sequencer #(.NWINDOWS(8), .TT_W(8)) dut (
    .clk(clk), .reset(reset), .exc_req(exc_req), .ticc_req(ticc_req),
    .ticc_num(ticc_num), .irl(irl), .psr_et(psr_et), .psr_pil(psr_pil),
    .psr_cwp(psr_cwp), .dp_hold(dp_hold), .tt(tt), .trap_busy(trap_busy),
    .psr_trap_wr(psr_trap_wr), .new_cwp(new_cwp), .rf_we(rf_we), .rf_sel(rf_sel),
    .tbr_tt_wr(tbr_tt_wr), .pc_load_tbr(pc_load_tbr), .error_mode(error_mode)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] exc;
    logic       ticc;
    logic [6:0] num;
    logic [3:0] irl;
    logic [3:0] pil;
    logic       et;
    logic [2:0] cwp;
  } stim_t;

  typedef struct {
    string      name;
    stim_t      s;
    logic       trap;
    logic       err;
    logic [7:0] tt;
    logic [2:0] cwp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] strb();
    return {psr_trap_wr, tbr_tt_wr, rf_we, rf_sel, pc_load_tbr};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_req();
    exc_req = '0; ticc_req = 1'b0; ticc_num = '0; irl = '0;
  endtask

  task automatic drive(input stim_t s);
    exc_req = s.exc; ticc_req = s.ticc; ticc_num = s.num; irl = s.irl;
    psr_pil = s.pil; psr_et = s.et; psr_cwp = s.cwp;
  endtask

  task automatic do_reset(input string name);
    step();
    reset = 1'b1;
    #1;
    chk({name, "_rst_strb"}, 32'(strb()), 32'h0);
    chk({name, "_rst_busy"}, 32'(trap_busy), 32'h0);
    chk({name, "_rst_err"}, 32'(error_mode), 32'h0);
    step();
    reset = 1'b0;
  endtask

  // Behavioural model: source priority and trap types from first principles.
  function automatic void model(input stim_t s, output logic trap, output logic err,
                                output logic [7:0] ett, output logic [2:0] ecwp);
    int codes[9] = '{1, 3, 2, 4, 5, 6, 7, 9, 10};
    int lowest = -1;
    for (int i = 0; i < 9; i++) if (s.exc[i] && lowest < 0) lowest = i;
    trap = 1'b0; err = 1'b0; ett = 8'h00;
    ecwp = 3'((int'(s.cwp) + 7) % 8);
    if (lowest >= 0 || s.ticc) begin
      if (!s.et) err = 1'b1;
      else begin
        trap = 1'b1;
        ett = (lowest >= 0) ? 8'(codes[lowest]) : 8'(128 + int'(s.num));
      end
    end else if (s.et && s.irl != 0 && (s.irl == 15 || s.irl > s.pil)) begin
      trap = 1'b1;
      ett = 8'(16 + int'(s.irl));
    end
  endfunction

  // Apply one request from IDLE and check the whole resulting sequence.
  task automatic run_vec(input string name, input stim_t s, input logic trap,
                         input logic err, input logic [7:0] ett, input logic [2:0] ecwp);
    drive(s);
    @(negedge clk);
    chk({name, "_busy0"}, 32'(trap_busy), 32'(trap | err));
    step();
    if (!trap && !err) begin
      @(negedge clk);
      chk({name, "_idle_busy"}, 32'(trap_busy), 32'h0);
      chk({name, "_idle_strb"}, 32'(strb()), 32'h0);
      clear_req();
    end else if (err) begin
      clear_req();
      @(negedge clk);
      chk({name, "_errmode"}, 32'(error_mode), 32'h1);
      chk({name, "_errbusy"}, 32'(trap_busy), 32'h1);
      chk({name, "_errstrb"}, 32'(strb()), 32'h0);
      step();
      @(negedge clk);
      chk({name, "_errsticky"}, 32'(error_mode), 32'h1);
      do_reset(name);
    end else begin
      clear_req();
      @(negedge clk);
      chk({name, "_enter"}, 32'(strb()), 32'h18);
      chk({name, "_tt"}, 32'(tt), 32'(ett));
      chk({name, "_cwp"}, 32'(new_cwp), 32'(ecwp));
      step(); @(negedge clk);
      chk({name, "_savepc"}, 32'(strb()), 32'h04);
      step(); @(negedge clk);
      chk({name, "_savenpc"}, 32'(strb()), 32'h06);
      step(); @(negedge clk);
      chk({name, "_vector"}, 32'(strb()), 32'h01);
      step(); @(negedge clk);
      chk({name, "_done_busy"}, 32'(trap_busy), 32'h0);
      chk({name, "_done_strb"}, 32'(strb()), 32'h0);
    end
    step();
  endtask

  vec_t tbl[$];

  function automatic vec_t mk(input string n, input logic [8:0] e, input logic tc,
                              input logic [6:0] nm, input logic [3:0] ir, input logic [3:0] pl,
                              input logic et, input logic [2:0] cw, input logic tr,
                              input logic er, input logic [7:0] t, input logic [2:0] c);
    vec_t v;
    v.name = n; v.s.exc = e; v.s.ticc = tc; v.s.num = nm; v.s.irl = ir;
    v.s.pil = pl; v.s.et = et; v.s.cwp = cw; v.trap = tr; v.err = er; v.tt = t; v.cwp = c;
    return v;
  endfunction

  initial begin
    stim_t s;
    logic  m_trap, m_err;
    logic [7:0] m_tt;
    logic [2:0] m_cwp;
    int first_pc, n_pc_we, held_strb;

    reset = 1'b1; dp_hold = 1'b0; psr_et = 1'b1; psr_pil = '0; psr_cwp = '0;
    clear_req();

    tbl.push_back(mk("illegal",   9'h004, 0, 7'h00, 4'd0,  4'd0,  1, 3'd3, 1, 0, 8'h02, 3'd2));
    tbl.push_back(mk("all_win",   9'h1F0, 1, 7'h11, 4'd15, 4'd0,  1, 3'd5, 1, 0, 8'h05, 3'd4));
    tbl.push_back(mk("ticc22",    9'h000, 1, 7'h22, 4'd0,  4'd0,  1, 3'd1, 1, 0, 8'hA2, 3'd0));
    tbl.push_back(mk("irl_eqpil", 9'h000, 0, 7'h00, 4'd5,  4'd5,  1, 3'd4, 0, 0, 8'h00, 3'd0));
    tbl.push_back(mk("irl6",      9'h000, 0, 7'h00, 4'd6,  4'd5,  1, 3'd4, 1, 0, 8'h16, 3'd3));
    tbl.push_back(mk("nmi15",     9'h000, 0, 7'h00, 4'd15, 4'd15, 1, 3'd6, 1, 0, 8'h1F, 3'd5));
    tbl.push_back(mk("irl_et0",   9'h000, 0, 7'h00, 4'd9,  4'd0,  0, 3'd2, 0, 0, 8'h00, 3'd0));
    tbl.push_back(mk("irl0",      9'h000, 0, 7'h00, 4'd0,  4'd0,  1, 3'd2, 0, 0, 8'h00, 3'd0));
    tbl.push_back(mk("cwp_wrap",  9'h001, 0, 7'h00, 4'd0,  4'd0,  1, 3'd0, 1, 0, 8'h01, 3'd7));
    tbl.push_back(mk("priv",      9'h002, 0, 7'h00, 4'd0,  4'd0,  1, 3'd7, 1, 0, 8'h03, 3'd6));
    tbl.push_back(mk("fpdis",     9'h008, 0, 7'h00, 4'd0,  4'd0,  1, 3'd1, 1, 0, 8'h04, 3'd0));
    tbl.push_back(mk("daccess",   9'h180, 0, 7'h00, 4'd0,  4'd0,  1, 3'd2, 1, 0, 8'h09, 3'd1));
    tbl.push_back(mk("tagovf",    9'h100, 1, 7'h7F, 4'd0,  4'd0,  1, 3'd2, 1, 0, 8'h0A, 3'd1));
    tbl.push_back(mk("err_exc",   9'h004, 0, 7'h00, 4'd0,  4'd0,  0, 3'd3, 0, 1, 8'h00, 3'd0));
    tbl.push_back(mk("err_ticc",  9'h000, 1, 7'h05, 4'd3,  4'd0,  0, 3'd3, 0, 1, 8'h00, 3'd0));

    step(); step();
    @(negedge clk);
    chk("reset_strb", 32'(strb()), 32'h0);
    chk("reset_busy", 32'(trap_busy), 32'h0);
    chk("reset_tt", 32'(tt), 32'h0);
    chk("reset_cwp", 32'(new_cwp), 32'h0);
    chk("reset_err", 32'(error_mode), 32'h0);
    step();
    reset = 1'b0;

    foreach (tbl[i]) run_vec(tbl[i].name, tbl[i].s, tbl[i].trap, tbl[i].err, tbl[i].tt, tbl[i].cwp);

    // Three held cycles in SAVE_PC push pc_load_tbr from cycle 4 to cycle 7.
    s = '{exc: 9'h040, ticc: 1'b0, num: 7'h0, irl: 4'd0, pil: 4'd0, et: 1'b1, cwp: 3'd4};
    drive(s);
    first_pc = -1; n_pc_we = 0; held_strb = 0;
    for (int c = 0; c < 12; c++) begin
      dp_hold = (c >= 2 && c <= 4);
      if (c == 1) clear_req();
      @(negedge clk);
      if (pc_load_tbr && first_pc < 0) first_pc = c;
      if (rf_we && !rf_sel) n_pc_we++;
      if (dp_hold && strb() != 5'h0) held_strb++;
      if (dp_hold && c >= 2) chk("hold_busy", 32'(trap_busy), 32'h1);
      step();
    end
    dp_hold = 1'b0;
    chk("hold_pc_cycle", 32'(first_pc), 32'd7);
    chk("hold_pc_we", 32'(n_pc_we), 32'd1);
    chk("hold_no_strb", 32'(held_strb), 32'd0);
    chk("hold_tt", 32'(tt), 32'h07);

    // Asynchronous reset while in SAVE_NPC.
    s = '{exc: 9'h020, ticc: 1'b0, num: 7'h0, irl: 4'd0, pil: 4'd0, et: 1'b1, cwp: 3'd2};
    drive(s);
    step(); clear_req();
    step(); step();
    @(negedge clk);
    chk("rst_mid_npc", 32'(strb()), 32'h06);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_strb", 32'(strb()), 32'h0);
    chk("rst_mid_busy", 32'(trap_busy), 32'h0);
    chk("rst_mid_tt", 32'(tt), 32'h0);
    chk("rst_mid_cwp", 32'(new_cwp), 32'h0);
    step();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst_after_strb", 32'(strb()), 32'h0);
      chk("rst_after_busy", 32'(trap_busy), 32'h0);
      step();
    end

    for (int k = 0; k < 150; k++) begin
      s.exc  = ($urandom_range(0, 2) == 0) ? 9'($urandom) : 9'h000;
      s.ticc = ($urandom_range(0, 3) == 0);
      s.num  = 7'($urandom);
      s.irl  = 4'($urandom);
      s.pil  = 4'($urandom);
      s.et   = ($urandom_range(0, 5) != 0);
      s.cwp  = 3'($urandom);
      model(s, m_trap, m_err, m_tt, m_cwp);
      run_vec($sformatf("rnd%0d", k), s, m_trap, m_err, m_tt, m_cwp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
